// File: rtl/scalar_wb_pkg.sv
// Shared writeback types and default widths.
// Used by scalar_wb_arbiter and by scalar_reg_file benches.
package scalar_wb_pkg;
   localparam int REG_SIZE   = 8;
   localparam int REG_QTY    = 4;
   localparam int SEL_BITS   = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int PTR_BITS   = 2;

   typedef struct packed {
      logic [SEL_BITS-1:0] dst;
      logic [REG_SIZE-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/scalar_wb_arbiter_fifo.sv
// Two-write/one-read circular buffer with occupancy count.
// Ports: we0/wd0 first slot, we1/wd1 second slot (only with we0),
// re dequeue, head entry, count, per-slot valid and tag fields.
module wb_fifo
   import scalar_wb_pkg::*;
#(
   parameter int DW    = REG_SIZE + SEL_BITS,
   parameter int TW    = SEL_BITS,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int PB    = PTR_BITS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we0,
   input  logic [DW-1:0]             wd0,
   input  logic                      we1,
   input  logic [DW-1:0]             wd1,
   input  logic                      re,
   output logic [DW-1:0]             head,
   output logic [PB:0]               count,
   output logic [DEPTH-1:0]          vld,
   output logic [DEPTH-1:0][TW-1:0]  tags
);
   logic [PB-1:0] wrPtr, rdPtr, wrNext;
   logic [DEPTH-1:0][DW-1:0] bufQ;

   // second slot lands one past the first, wrapping naturally
   assign wrNext = wrPtr + PB'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         wrPtr <= wrPtr + PB'(we0) + PB'(we1);
         rdPtr <= rdPtr + PB'(re);
         count <= count + (PB+1)'(we0) + (PB+1)'(we1) - (PB+1)'(re);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (we0) bufQ[wrPtr] <= wd0;
         if (we1) bufQ[wrNext] <= wd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (count <= (PB+1)'(DEPTH));
   end

   assign head = bufQ[rdPtr];

   // slot i is live when its distance from the read pointer
   // is below the occupancy
   always_comb begin
      vld  = '0;
      tags = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld[i]  = {1'b0, PB'(i) - rdPtr} < count;
         tags[i] = bufQ[i][DW-1 -: TW];
      end
   end
endmodule

// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-return writes into one
// register-file write port through an in-order queue; exports pendingMask.
module scalar_wb_arbiter
   import scalar_wb_pkg::*;
#(
   parameter int regSize     = REG_SIZE,
   parameter int regQuantity = REG_QTY,
   parameter int selBits     = SEL_BITS,
   parameter int fifoDepth   = FIFO_DEPTH,
   parameter int ptrBits     = PTR_BITS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   aluValid,
   input  logic [selBits-1:0]     aluReg,
   input  logic [regSize-1:0]     aluData,
   output logic                   aluReady,
   input  logic                   memValid,
   input  logic [selBits-1:0]     memReg,
   input  logic [regSize-1:0]     memData,
   output logic                   memReady,
   input  logic                   wbStall,
   output logic                   regWrEn,
   output logic [selBits-1:0]     regToWrite,
   output logic [regSize-1:0]     regWrData,
   output logic [regQuantity-1:0] pendingMask,
   output logic [ptrBits:0]       fifoCount
);
   localparam int EW = selBits + regSize;
   localparam logic [ptrBits:0] FULL = fifoDepth[ptrBits:0];
   localparam logic [ptrBits:0] ONE  = 1;

   logic [ptrBits:0] free;
   logic memAcc, aluAcc;
   logic we0, we1;
   logic [EW-1:0] wd0, wd1, head;
   logic [fifoDepth-1:0] vld;
   logic [fifoDepth-1:0][selBits-1:0] tags;

   // ready uses only the registered count; a same-edge drain is not credited
   assign free     = FULL - fifoCount;
   assign memReady = !reset && (free != '0);
   assign aluReady = !reset && ((free > ONE) || (free == ONE && !memValid));

   assign memAcc = memValid && memReady;
   assign aluAcc = aluValid && aluReady;

   // mem is older, so it takes the first slot when both land together
   assign we0 = memAcc || aluAcc;
   assign we1 = memAcc && aluAcc;
   assign wd0 = memAcc ? {memReg, memData} : {aluReg, aluData};
   assign wd1 = {aluReg, aluData};

   assign regWrEn    = !reset && (fifoCount != '0) && !wbStall;
   assign regToWrite = (fifoCount != '0) ? head[EW-1 -: selBits] : '0;
   assign regWrData  = (fifoCount != '0) ? head[regSize-1:0] : '0;

   always_comb begin
      pendingMask = '0;
      for (int i = 0; i < fifoDepth; i++)
         if (vld[i]) pendingMask[tags[i]] = 1'b1;
   end

   wb_fifo #(
      .DW(EW), .TW(selBits), .DEPTH(fifoDepth), .PB(ptrBits)
   ) u_fifo (
      .clk(clk), .reset(reset),
      .we0(we0), .wd0(wd0),
      .we1(we1), .wd1(wd1),
      .re(regWrEn), .head(head), .count(fifoCount),
      .vld(vld), .tags(tags)
   );
endmodule
